// File: rtl/pwm_seq_ctrl.sv
// pwm_seq_ctrl: streams samples from memory into a PWM duty register, one sample per rep+1 PWM periods
`timescale 1ns/1ps
module pwm_seq_ctrl #(
  parameter int AW = 16,
  parameter int DW = 12,
  parameter int MEM_LAT = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_en,
  input  logic [3:0]    rep,
  input  logic [AW-1:0] addr_ini,
  input  logic [AW-1:0] addr_fim,
  input  logic          periodo_fim,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] amostra,
  output logic          carga,
  output logic          busy,
  output logic          fim,
  output logic          erro,
  output logic          underrun
);
  localparam logic [DW-1:0] L_MID = {1'b1, {(DW-1){1'b0}}};
  localparam logic [2:0] L_LAST = 3'(MEM_LAT - 1);
  typedef enum logic [1:0] {IDLE, LER, ESPERA, PRONTO} state_t;
  state_t r_state, w_next;
  logic [AW-1:0] r_ini, r_fim, r_a;
  logic [DW-1:0] r_buf, r_amostra;
  logic [3:0] r_rep, r_cnt;
  logic [2:0] r_lat;
  logic r_loop, r_first, r_last, r_carga, r_fim_p, r_erro, r_under;
  logic w_go, w_bad, w_top, w_load, w_done, w_cap, w_end, w_pref;
  assign w_go   = start && !stop && r_state == IDLE && addr_fim >= addr_ini;
  assign w_bad  = start && !stop && r_state == IDLE && addr_fim < addr_ini;
  assign w_top  = r_cnt == r_rep;
  assign w_load = periodo_fim && r_state == PRONTO && w_top;
  assign w_done = w_load && r_last;
  assign w_cap  = r_state == ESPERA && r_lat == L_LAST;
  assign w_end  = r_a == r_fim;
  assign w_pref = w_load && !r_last && (!w_end || r_loop);
  assign mem_rd   = r_state == LER;
  assign mem_addr = r_a;
  assign busy     = r_state != IDLE;
  assign amostra  = r_amostra;
  assign carga    = r_carga;
  assign fim      = r_fim_p;
  assign erro     = r_erro;
  assign underrun = r_under;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (stop) w_next = IDLE;
    else
      unique case (r_state)
        IDLE:    w_next = w_go ? LER : IDLE;
        LER:     w_next = ESPERA;
        ESPERA:  w_next = w_cap ? PRONTO : ESPERA;
        PRONTO:  w_next = w_done ? IDLE : (w_pref ? LER : PRONTO);
        default: w_next = IDLE;
      endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ini     <= '0;
      r_fim     <= '0;
      r_a       <= '0;
      r_buf     <= '0;
      r_amostra <= L_MID;
      r_rep     <= '0;
      r_cnt     <= '0;
      r_lat     <= '0;
      r_loop    <= 1'b0;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
      r_carga   <= 1'b0;
      r_fim_p   <= 1'b0;
      r_erro    <= 1'b0;
      r_under   <= 1'b0;
    end else begin
      r_carga <= 1'b0;
      r_fim_p <= w_done && !stop;
      r_erro  <= w_bad;
      if (w_go) begin
        r_ini   <= addr_ini;
        r_fim   <= addr_fim;
        r_rep   <= rep;
        r_loop  <= loop_en;
        r_a     <= addr_ini;
        // counter starts saturated so the first sample loads on the first period after the fill
        r_cnt   <= rep;
        r_first <= 1'b1;
        r_last  <= 1'b0;
        r_under <= 1'b0;
      end
      r_lat <= r_state == ESPERA ? r_lat + 3'd1 : 3'd0;
      if (w_cap) r_buf <= mem_data;
      if (periodo_fim && r_state != IDLE) r_cnt <= w_load ? 4'd0 : (w_top ? r_cnt : r_cnt + 4'd1);
      if (periodo_fim && w_top && !r_first && (r_state == LER || r_state == ESPERA)) r_under <= 1'b1;
      if (w_load && !r_last) begin
        r_amostra <= r_buf;
        r_carga   <= 1'b1;
        r_first   <= 1'b0;
        r_a       <= w_end ? (r_loop ? r_ini : r_a) : r_a + 1'b1;
        r_last    <= w_end && !r_loop;
      end
      if (stop) begin
        r_amostra <= L_MID;
        r_carga   <= 1'b1;
      end else if (w_done) r_amostra <= L_MID;
    end
  end
endmodule

// File: doc/pwm_seq_ctrl.md
PWM_SEQ_CTRL -- requirements
Module: pwm_seq_ctrl

Interface
REQ-001 Parameter AW, default 16, sample memory address width.
REQ-002 Parameter DW, default 12, sample/PWM duty width.
REQ-003 Parameter MEM_LAT, default 1, memory read latency in cycles, range 1..7.
REQ-004 Port clock  in  1  single system clock; all logic on rising edge.
REQ-005 Port reset_n  in  1  asynchronous active-low reset.
REQ-006 Port start  in  1  one-cycle request to begin playback.
REQ-007 Port stop  in  1  one-cycle request to abort playback.
REQ-008 Port loop_en  in  1  when 1, playback wraps from addr_fim back to addr_ini.
REQ-009 Port rep  in  4  each sample is presented for rep+1 PWM periods.
REQ-010 Port addr_ini / addr_fim  in  AW each  first and last sample address, inclusive.
REQ-011 Port periodo_fim  in  1  one-cycle pulse from the PWM when its counter wraps.
REQ-012 Port mem_rd / mem_addr  out  1 / AW  read strobe and address.
REQ-013 Port mem_data  in  DW  read data, valid MEM_LAT cycles after mem_rd.
REQ-014 Port amostra / carga  out  DW / 1  duty value to PWM and one-cycle load strobe.
REQ-015 Port busy / fim / erro / underrun  out  1 each  status: playing; done pulse; bad-range pulse; sticky underrun flag.

Function
REQ-016 States: IDLE, LER (issue read), ESPERA (latency count), PRONTO (buffer full, waiting for the load point).
REQ-017 IDLE: start with addr_fim >= addr_ini latches addr_ini, addr_fim, rep, and loop_en, sets A=addr_ini, clears underrun, and enters LER; busy=1 from the next cycle.
REQ-018 IDLE: start with addr_fim < addr_ini produces a one-cycle erro pulse and remains in IDLE.
REQ-019 LER lasts exactly one cycle with mem_rd=1 and mem_addr=A, then enters ESPERA; mem_rd is 0 in every other state.
REQ-020 ESPERA counts MEM_LAT cycles, captures mem_data into the buffer on the last count, then enters PRONTO.
REQ-021 Load point: a periodo_fim occurring in PRONTO while the repeat counter equals the latched rep.
REQ-022 At the load point: amostra<=buffer, carga=1 for that one cycle, repeat counter<=0, next A computed, then LER (prefetch).
REQ-023 A periodo_fim that is not a load point increments the repeat counter, saturating at the latched rep.
REQ-024 Repeat counting continues during LER and ESPERA, so playback of the current sample is independent of prefetch.
REQ-025 Next A: if A != addr_fim, A+1.
REQ-026 Next A: if A == addr_fim and loop_en=1, addr_ini.
REQ-027 Next A: if A == addr_fim and loop_en=0, no prefetch; the controller waits rep+1 further periods, then pulses fim for one cycle, returns to IDLE, and sets amostra=2^(DW-1).
REQ-028 Underrun: a periodo_fim in LER/ESPERA with the repeat counter equal to rep sets underrun; amostra holds its value, and the load happens at the first periodo_fim after PRONTO is reached.
REQ-029 addr_fim == addr_ini plays a single sample, or repeats it indefinitely when loop_en=1.
REQ-030 Arithmetic on A is modulo 2^AW; because addr_fim bounds A, wrap past 2^AW-1 cannot occur.
REQ-031 start while busy=1 is ignored; changes to configuration inputs while busy=1 are ignored.
REQ-032 stop in any state returns to IDLE on the next cycle with amostra=2^(DW-1), carga=1 for one cycle, and no fim pulse.
REQ-033 stop and start asserted in the same cycle: stop wins and start is discarded.
REQ-034 Initial fill: after start, the first sample is loaded at the first periodo_fim after PRONTO is reached, with no underrun flagged.

Reset
REQ-035 reset_n=0 forces IDLE, A=0, buffer=0, and repeat counter=0.
REQ-036 reset_n=0 forces amostra=2^(DW-1) (0x800 for DW=12) and carga=0.
REQ-037 reset_n=0 forces mem_rd=0, mem_addr=0, busy=0, fim=0, erro=0, and underrun=0.
REQ-038 Reset mid-operation abandons any outstanding read; mem_data returned after reset is discarded.

Verification
REQ-039 Basic sequence: DW=12, MEM_LAT=1, addr 0x0010..0x0013, rep=0, loop_en=0, memory 0x100/0x200/0x300/0x400, periodo_fim every 4096 cycles -> carga values 0x100, 0x200, 0x300, 0x400 on consecutive periods, then fim pulse, amostra=0x800, busy=0.
REQ-040 Repeat and loop: rep=2, loop_en=1, addr 5..6 -> each sample held for 3 periods; mem_addr sequence 5,6,5,6,...; fim never pulses.
REQ-041 Underrun: MEM_LAT=7, periodo_fim every 4 cycles -> underrun=1 and carga skips periods; after a new start, underrun=0.
REQ-042 Bad range and single sample: addr_ini=9, addr_fim=8 -> erro pulse, busy stays 0; addr_ini=addr_fim=9, loop_en=0 -> one carga, then fim.
REQ-043 Abort: stop asserted during ESPERA, and stop+start in the same cycle -> IDLE next cycle, amostra=0x800, no fim.
REQ-044 Async reset: reset_n low for 3 ns mid-PRONTO, between clock edges -> outputs take reset values immediately, and the late mem_data is ignored.
